// File: rtl/beta_solve_pkg.sv
// Widths and state encoding shared across the regression datapath
// (MAT_INV, XTY, beta_solve and the continuation-value stage).
package option_pkg;

  localparam int unsigned INV_W     = 32;
  localparam int unsigned INV_FRAC  = 16;
  localparam int unsigned XTY_W     = 24;
  localparam int unsigned BETA_W    = 32;
  localparam int unsigned BETA_FRAC = 16;
  localparam int unsigned ACC_W     = INV_W + XTY_W + 2;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    OUT
  } beta_state_t;

endpackage

// File: rtl/beta_solve_if.sv
// Handshake bundle for beta_solve: inverse rows and XtY in, beta out.
interface beta_solve_if import option_pkg::*;;

  logic                     inv_valid;
  logic                     inv_ready;
  logic signed [INV_W-1:0]  inv_row0;
  logic signed [INV_W-1:0]  inv_row1;
  logic signed [INV_W-1:0]  inv_row2;

  logic                     xty_valid;
  logic                     xty_ready;
  logic signed [XTY_W-1:0]  xty0;
  logic signed [XTY_W-1:0]  xty1;
  logic signed [XTY_W-1:0]  xty2;

  logic                     beta_valid;
  logic                     beta_ready;
  logic signed [BETA_W-1:0] beta0;
  logic signed [BETA_W-1:0] beta1;
  logic signed [BETA_W-1:0] beta2;
  logic                     beta_sat;
  logic                     busy;

  modport master (
    output inv_valid, inv_row0, inv_row1, inv_row2,
    output xty_valid, xty0, xty1, xty2,
    output beta_ready,
    input  inv_ready, xty_ready,
    input  beta_valid, beta0, beta1, beta2, beta_sat, busy
  );

  modport slave (
    input  inv_valid, inv_row0, inv_row1, inv_row2,
    input  xty_valid, xty0, xty1, xty2,
    input  beta_ready,
    output inv_ready, xty_ready,
    output beta_valid, beta0, beta1, beta2, beta_sat, busy
  );

endinterface

// File: rtl/beta_solve_fx_mac.sv
// Signed multiply-accumulate with clear; finalize output is the shifted,
// saturated view of the sum being written this cycle.
module fx_mac #(
  parameter int unsigned A_W   = 32,
  parameter int unsigned B_W   = 24,
  parameter int unsigned ACC_W = 58,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [OUT_W-1:0] fin_o,
  output logic                    sat_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-OUT_W:0]    top_bits;
  logic                    fits;

  assign prod     = ACC_W'(a_i) * ACC_W'(b_i);
  assign acc_d    = (clr_i ? '0 : acc_q) + prod;
  assign shifted  = acc_d >>> SHIFT;
  // Representable in OUT_W signed only if everything above the output sign bit
  // is a copy of it.
  assign top_bits = shifted[ACC_W-1:OUT_W-1];
  assign fits     = (top_bits == '0) || (top_bits == '1);

  always_comb begin
    sat_o = !fits;
    fin_o = shifted[OUT_W-1:0];
    if (!fits) begin
      fin_o = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/beta_solve.sv
// Collects (XtX)^-1 rows and XtY, computes beta = inv * xty with one shared
// MAC over 9 cycles, and presents beta0..2 over a valid/ready handshake.
module beta_solve import option_pkg::*; (
  input logic         clk,
  input logic         rst,
  beta_solve_if.slave bus
);

  beta_state_t state_q, state_d;

  logic [1:0]               row_cnt_q;
  logic                     xty_held_q;
  logic [1:0]               r_q;
  logic [1:0]               c_q;
  logic                     sat_q;
  logic signed [INV_W-1:0]  inv_q  [3][3];
  logic signed [XTY_W-1:0]  xty_q  [3];
  logic signed [BETA_W-1:0] beta_q [3];

  logic                     inv_hs;
  logic                     xty_hs;
  logic                     rows_done;
  logic                     xty_done;
  logic                     load_done;
  logic                     mac_en;
  logic                     mac_clr;
  logic signed [INV_W-1:0]  mac_a;
  logic signed [XTY_W-1:0]  mac_b;
  logic signed [BETA_W-1:0] mac_fin;
  logic                     mac_sat;

  assign bus.inv_ready  = (state_q == LOAD) && (row_cnt_q != 2'd3) && !rst;
  assign bus.xty_ready  = (state_q == LOAD) && !xty_held_q && !rst;
  assign bus.beta_valid = (state_q == OUT);
  assign bus.busy       = (state_q != LOAD);
  assign bus.beta0      = beta_q[0];
  assign bus.beta1      = beta_q[1];
  assign bus.beta2      = beta_q[2];
  assign bus.beta_sat   = sat_q;

  assign inv_hs    = bus.inv_valid && bus.inv_ready;
  assign xty_hs    = bus.xty_valid && bus.xty_ready;
  // Both streams may complete on the same edge; CALC entry looks at what
  // will be held after this edge, not what is held now.
  assign rows_done = (row_cnt_q == 2'd3) || ((row_cnt_q == 2'd2) && inv_hs);
  assign xty_done  = xty_held_q || xty_hs;
  assign load_done = (state_q == LOAD) && rows_done && xty_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done) state_d = CALC;
      CALC:    if ((r_q == 2'd2) && (c_q == 2'd2)) state_d = OUT;
      OUT:     if (bus.beta_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      if (c_q == 2'(c)) begin
        mac_b = xty_q[c];
        for (int unsigned r = 0; r < 3; r++) begin
          if (r_q == 2'(r)) mac_a = inv_q[r][c];
        end
      end
    end
  end

  assign mac_en  = (state_q == CALC);
  assign mac_clr = (c_q == 2'd0);

  fx_mac #(
    .A_W   (INV_W),
    .B_W   (XTY_W),
    .ACC_W (ACC_W),
    .OUT_W (BETA_W),
    .SHIFT (INV_FRAC - BETA_FRAC)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .fin_o (mac_fin),
    .sat_o (mac_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_q  <= '0;
      xty_held_q <= 1'b0;
      r_q        <= '0;
      c_q        <= '0;
      sat_q      <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        xty_q[r]  <= '0;
        beta_q[r] <= '0;
        for (int unsigned c = 0; c < 3; c++) inv_q[r][c] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (inv_hs) begin
            for (int unsigned r = 0; r < 3; r++) begin
              if (row_cnt_q == 2'(r)) begin
                inv_q[r][0] <= bus.inv_row0;
                inv_q[r][1] <= bus.inv_row1;
                inv_q[r][2] <= bus.inv_row2;
              end
            end
            row_cnt_q <= row_cnt_q + 2'd1;
          end
          if (xty_hs) begin
            xty_q[0]   <= bus.xty0;
            xty_q[1]   <= bus.xty1;
            xty_q[2]   <= bus.xty2;
            xty_held_q <= 1'b1;
          end
          if (load_done) begin
            r_q   <= '0;
            c_q   <= '0;
            sat_q <= 1'b0;
          end
        end
        CALC: begin
          if (c_q == 2'd2) begin
            for (int unsigned r = 0; r < 3; r++) begin
              if (r_q == 2'(r)) beta_q[r] <= mac_fin;
            end
            sat_q <= sat_q | mac_sat;
            c_q   <= '0;
            r_q   <= r_q + 2'd1;
          end else begin
            c_q <= c_q + 2'd1;
          end
        end
        OUT: begin
          if (bus.beta_ready) begin
            row_cnt_q  <= '0;
            xty_held_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/beta_solve.md
# beta_solve

Regression-coefficient stage of the option-pricing datapath, directly downstream of `MAT_INV`. It collects the three rows of the inverted 3x3 normal matrix (XᵀX)⁻¹ from `MAT_INV` and the XᵀY vector from the `XTY` accumulator. It then computes β = (XᵀX)⁻¹·XᵀY with one shared signed multiply-accumulate over 9 cycles. The resulting β0..β2 are presented to the continuation-value stage over a valid/ready handshake.

## Interface
- `INV_W`, 32: signed width of an inverse-matrix entry.
- `INV_FRAC`, 16: fraction bits of an inverse entry.
- `XTY_W`, 24: signed integer width of an XᵀY entry.
- `BETA_W`, 32: signed width of a β output.
- `BETA_FRAC`, 16: fraction bits of β. Must be ≤ `INV_FRAC`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  **synchronous, active-high reset**.
- `inv_valid`  in  1  inverse row beat valid.
- `inv_row0`, `inv_row1`, `inv_row2`  in  `INV_W` each  columns 0..2 of the current inverse row.
- `inv_ready`  out  1  block accepts an inverse row.
- `xty_valid`  in  1  XᵀY vector valid.
- `xty0`, `xty1`, `xty2`  in  `XTY_W` each  XᵀY entries.
- `xty_ready`  out  1  block accepts the XᵀY vector.
- `beta_valid`  out  1  β result valid.
- `beta0`, `beta1`, `beta2`  out  `BETA_W` each  coefficients.
- `beta_sat`  out  1  any β in the current result saturated.
- `beta_ready`  in  1  downstream accepts β.
- `busy`  out  1  high in CALC and OUT.

## Operation
- FSM states: LOAD → CALC → OUT → LOAD.
- **LOAD**
  - A handshake occurs when valid and ready are both high on the same edge.
  - Inverse rows are taken in order: the 1st, 2nd and 3rd inverse handshakes give rows 0, 1 and 2. A 2-bit row counter tracks them.
  - `inv_ready` = (state==LOAD) && (row count < 3) && !rst.
  - `xty_ready` = (state==LOAD) && !xty_held && !rst. The XᵀY vector is a single beat.
  - The inverse and XᵀY streams are independent. Any interleaving is legal, including the last beats of both arriving in the same cycle.
  - A valid input while its ready is low is ignored. The upstream stage holds it.
- **LOAD → CALC**: on the edge where 3 rows are held and the XᵀY vector is held.
- **CALC**
  - Step counter k = 0..8, with r = k/3 and c = k%3.
  - Each step: acc ← (c==0 ? 0 : acc) + inv[r][c]·xty[c].
  - acc is a signed register of `INV_W`+`XTY_W`+2 bits.
  - At c==2, the finished sum is written to beta_r: arithmetic shift right by `INV_FRAC`−`BETA_FRAC` (floor), then saturate to `BETA_W` signed.
  - Saturation ORs into a sticky flag. The flag is cleared on entry to CALC.
- **OUT**
  - `beta_valid` = 1. `beta0`..`beta2` and `beta_sat` are held stable until the handshake with `beta_ready`.
  - After the handshake: return to LOAD, clear the row counter and `xty_held`, deassert `beta_valid`.
  - The β registers keep their values until the next result is written.
- **Reset** (any state, including mid-CALC or in OUT with the handshake pending):
  - State ← LOAD; counters, held flags, acc and β registers are cleared.
  - Partial loads and results are discarded.
- **Reset values**:
  - `beta0`..`beta2` = 0.
  - `beta_valid`, `beta_sat`, `busy` = 0.
  - `inv_ready` and `xty_ready` are 0 while `rst` is high, and 1 in the first cycle after `rst` falls.

## Timing
- Let cycle 0 be the edge of the last load handshake.
- CALC steps run on edges 1..9. The β registers update on edges 3, 6 and 9.
- `beta_valid` is high from cycle 9 (after edge 9).
- If `beta_ready` is already high, the handshake completes on edge 10. `beta_valid` is then high for exactly one cycle, and both ready outputs are high after edge 10.
- Minimum throughput: 13 cycles per β set (3 LOAD beats + 9 CALC + 1 OUT).
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output except the `!rst` gating of the ready outputs.

## Structure
- Shared package `option_pkg`:
  - width localparams `INV_W`, `INV_FRAC`, `XTY_W`, `BETA_W`, `BETA_FRAC`, shared with `MAT_INV`, `XTY` and the continuation-value stage;
  - the `beta_state_t` enum {LOAD, CALC, OUT}.
- One sub-module: `fx_mac`, a signed multiply-accumulate with clear input, plus a shift-and-saturate finalize output and a saturation flag. The FSM, counters and operand muxes stay in `beta_solve`.

## Test plan
All values below are Q16.16: 65536 = 1.0.
- **Identity**: inverse = identity (65536 on the diagonal, 0 elsewhere), xty = (5, −3, 7) → beta = (327680, −196608, 458752), `beta_sat`=0, `beta_valid` rises at cycle 9.
- **Symmetric**: rows (32768, 16384, 0), (16384, 65536, −32768), (0, −32768, 131072), xty = (4, 8, 2) → beta = (262144, 524288, 0).
- **Ordering and backpressure**:
  - stimulus: xty first, inverse rows with 2-cycle gaps, `inv_valid` held high after the 3rd row, `beta_ready` low for 5 cycles;
  - required: no 4th row is accepted, β stays stable while `beta_ready` is low, and a single handshake completes.
- **Saturation**: row 0 all 0x7FFFFFFF, xty all 8388607 → `beta0` = 0x7FFFFFFF, `beta_sat`=1. A following identity run returns `beta_sat`=0.
- **Reset mid-CALC**:
  - stimulus: `rst` pulsed at CALC step 4;
  - required: outputs return to reset values, and a fresh identity load yields the correct β with no residue from the aborted run.
- **Simultaneous last beats**: the 3rd inverse row and xty handshake on the same edge → CALC starts on the next edge and β matches the identity case.
